// File: rtl/pool_window_feeder.sv
// ---------------------------------------------------------------------------
// pool_window_feeder
//
// Front end of the 2x2 average-pooling path. It takes the raster-order
// conv output stream, keeps one image line in a buffer and builds
// non-overlapping 2x2 windows (stride 2). It hands each window to the
// pooling unit with a start/finish handshake, then passes the pooled pixel
// downstream on a valid/ready port. The pooled value is not modified here.
//
// Parameters
//   DATA_W  pixel width, two's complement
//   IMG_W   feature-map width in pixels (>= 2)
//   IMG_H   feature-map height in pixels (>= 2)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input pixel handshake, in_pixel in raster order
//   pool_start          window is presented on win_00..win_11
//   win_00 / win_01     window top-left / top-right     ([r-1][c-1], [r-1][c])
//   win_10 / win_11     window bottom-left / bottom-right ([r][c-1], [r][c])
//   pool_finish         pooling unit done, pool_result valid while high
//   out_valid/out_ready output handshake, out_pixel is the pooled pixel
//   frame_done          one-cycle pulse the cycle after the last pixel of a
//                       frame is accepted
//   win_count           (only with POOL_WIN_CNT_EN) pooled pixels handed off
//                       in the current frame, saturating at 16'hFFFF
//
// Build option
//   POOL_WIN_CNT_EN     when defined, adds the win_count port and counter.
//
// State table
//   state    | meaning
//   ---------+----------------------------------------------------------
//   FILL     | accepting pixels, filling line buffer / left register
//   ISSUE    | window presented, pool_start high, waiting pool_finish
//   RELEASE  | result captured, waiting for pool_finish to drop
//   OUT      | out_valid high, waiting for out_ready
// ---------------------------------------------------------------------------
module pool_window_feeder #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              pool_start,
  output logic [DATA_W-1:0] win_00,
  output logic [DATA_W-1:0] win_01,
  output logic [DATA_W-1:0] win_10,
  output logic [DATA_W-1:0] win_11,
  input  logic              pool_finish,
  input  logic [DATA_W-1:0] pool_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
`ifdef POOL_WIN_CNT_EN
  output logic [15:0]       win_count,
`endif
  output logic              frame_done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  // Clears bit 0 of an odd column to get the left column of its pair.
  localparam logic [CW-1:0] EVEN_MASK = ~COL_ONE;

  localparam logic [1:0] S_FILL    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] line_buf [IMG_W];
  logic [DATA_W-1:0] left_px;

  logic accept;
  logic col_last;
  logic row_last;
  logic win_fire;
  logic [CW-1:0] col_pair;

  // Handshake outputs decode straight from the state register so that an
  // asynchronous reset drops pool_start/out_valid and raises in_ready at once.
  assign in_ready   = (state == S_FILL);
  assign pool_start = (state == S_ISSUE);
  assign out_valid  = (state == S_OUT);

  assign accept   = in_valid & in_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign col_pair = col & EVEN_MASK;

  // A window closes on the bottom-right pixel: odd row, odd column. With odd
  // IMG_W the last column is even and never closes one; with odd IMG_H the
  // last row is even and only lands in the line buffer.
  assign win_fire = accept & row[0] & col[0];

  // ---------------------------------------------------------------------
  // raster position
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
        end else begin
          row <= row + ROW_ONE;
        end
      end else begin
        col <= col + COL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & col_last & row_last;
    end
  end

  // ---------------------------------------------------------------------
  // pixel storage
  // ---------------------------------------------------------------------
  // Line buffer contents are don't-care after reset, so it has no reset and
  // can map onto plain storage.
  always_ff @(posedge clk) begin
    if (accept && !row[0]) begin
      line_buf[col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_px <= '0;
    end else if (accept && row[0] && !col[0]) begin
      left_px <= in_pixel;
    end
  end

  // Window registers only load from FILL (win_fire needs in_ready), so they
  // stay put while the pooling unit works on them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_00 <= '0;
      win_01 <= '0;
      win_10 <= '0;
      win_11 <= '0;
    end else if (win_fire) begin
      win_00 <= line_buf[col_pair];
      win_01 <= line_buf[col];
      win_10 <= left_px;
      win_11 <= in_pixel;
    end
  end

  // ---------------------------------------------------------------------
  // sequencing
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (win_fire) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pool_finish) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Do not go on until the pooling unit has dropped finish, otherwise
        // a long finish pulse could be taken for the next window's result.
        if (!pool_finish) begin
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_nxt = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pixel <= '0;
    end else if ((state == S_ISSUE) && pool_finish) begin
      out_pixel <= pool_result;
    end
  end

`ifdef POOL_WIN_CNT_EN
  // Counts handoffs in the current frame. The final window of a frame is
  // handed off after frame_done, so it lands in the next frame's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_count <= '0;
    end else if (frame_done) begin
      win_count <= '0;
    end else if (out_valid && out_ready && (win_count != 16'hFFFF)) begin
      win_count <= win_count + 16'd1;
    end
  end
`endif

endmodule
